// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// datapath width, instruction size and the default reset PC.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    // Size of one instruction word in bytes (sequential PC increment).
    localparam logic [31:0] INSTR_BYTES = 32'd4;

    // Low address bits that must be zero for a word-aligned fetch.
    localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    // HALT is only ever entered when FETCH_MISALIGN_CHK_EN is defined.
    typedef enum logic [2:0] {
        REQ,
        WAIT,
        HOLD,
        DROP,
        HALT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: registered PC, one outstanding word request to
// instruction memory, and a valid/ready hand-off of Instr/PC to decode.
// Branch/jump redirects load redirect_base + ImmExt into the PC; a request
// already in flight when a redirect arrives is drained and its data dropped.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned redirect target
// raises a sticky misalign_err and parks the FSM in HALT until reset).
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter int unsigned XLEN     = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_base,
    input  logic [XLEN-1:0] ImmExt,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            misalign_err
);
    import fetch_pkg::*;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic            req_valid_q, req_valid_d;
    logic            instr_valid_q, instr_valid_d;
    logic            err_q, err_d;
    logic [XLEN-1:0] target;
    logic            accept;

    assign target = redirect_base + ImmExt;
    assign accept = req_valid_q && imem_req_ready;

    // Next-state, PC and instruction-buffer logic; redirect overrides the
    // normal progression (and beats instr_ready in HOLD).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        err_d   = err_q;

        unique case (state_q)
            REQ:  if (accept) state_d = WAIT;
            WAIT: if (imem_rsp_valid) begin
                      instr_d = imem_rsp_data;
                      state_d = HOLD;
                  end
            HOLD: if (instr_ready) begin
                      pc_d    = pc_q + INSTR_BYTES;
                      state_d = REQ;
                  end
            DROP: if (imem_rsp_valid) state_d = REQ;
            HALT: state_d = HALT;
            default: state_d = REQ;
        endcase

        if (redirect && (state_q != HALT)) begin
            // Any response landing this cycle belongs to the old path.
            instr_d = instr_q;
`ifdef FETCH_MISALIGN_CHK_EN
            pc_d = target;
`else
            pc_d = target & ~ALIGN_MASK;
`endif
            unique case (state_q)
                REQ:     state_d = accept ? DROP : REQ;
                WAIT:    state_d = imem_rsp_valid ? REQ : DROP;
                HOLD:    state_d = REQ;
                DROP:    state_d = imem_rsp_valid ? REQ : DROP;
                default: state_d = state_q;
            endcase
`ifdef FETCH_MISALIGN_CHK_EN
            if ((target & ALIGN_MASK) != '0) begin
                err_d   = 1'b1;
                state_d = HALT;
            end
`endif
        end

        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    // State and registered handshake outputs; async active-low reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= REQ;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_MISALIGN_CHK_EN
    // Sticky misaligned-target flag, cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_q <= 1'b0;
        else          err_q <= err_d;
    end
`else
    assign err_q = 1'b0;
`endif

    assign imem_req_valid = req_valid_q;
    assign imem_addr      = pc_q;
    assign instr_valid    = instr_valid_q;
    assign Instr          = instr_q;
    assign PC             = pc_q;
    assign PCPlus4        = pc_q + INSTR_BYTES;
    assign misalign_err   = err_q;

    // Memory may only answer while a request is outstanding.
    a_no_stray_rsp: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rsp_valid |-> (state_q == WAIT || state_q == DROP || state_q == HALT));

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed + randomized bench for fetch_pc_unit. The reference is a
// transaction-level model: the expected fetch address advances by 4 per
// consumed instruction or jumps to base+imm on a redirect, and each word
// returned by the memory model is a fixed hash of its address.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_base = '0;
    logic [31:0] ImmExt = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] Instr;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        misalign_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [31:0] exp_pc = '0;
    logic [31:0] last_instr = '0;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .redirect(redirect), .redirect_base(redirect_base), .ImmExt(ImmExt),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_valid"}, {31'd0, imem_req_valid}, 32'd0);
        chk({tag, "_instr_valid"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_instr"}, Instr, 32'd0);
        chk({tag, "_misalign"}, {31'd0, misalign_err}, 32'd0);
        chk({tag, "_addr"}, imem_addr, 32'd0);
        chk({tag, "_pc"}, PC, 32'd0);
        chk({tag, "_pcplus4"}, PCPlus4, 32'd4);
    endtask

    // Bounded wait for the next fetch request, then check its address.
    task automatic wait_req();
        int unsigned n = 0;
        while (imem_req_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_addr, exp_pc);
    endtask

    // Issue one fetch up to the point where decode sees it in HOLD.
    task automatic fetch_to_hold(input int unsigned req_wait, input int unsigned rsp_lat,
                                 input int unsigned hold_wait, input logic [31:0] data);
        wait_req();
        imem_req_ready = 1'b0;
        for (int unsigned i = 0; i < req_wait; i++) begin
            step();
            chk("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", imem_addr, exp_pc);
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_no_instr", {31'd0, instr_valid}, 32'd0);
        for (int unsigned i = 1; i < rsp_lat; i++) step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom;
        chk("instr_valid", {31'd0, instr_valid}, 32'd1);
        chk("instr", Instr, data);
        chk("pc", PC, exp_pc);
        chk("pcplus4", PCPlus4, exp_pc + 32'd4);
        last_instr = data;
        for (int unsigned i = 0; i < hold_wait; i++) begin
            step();
            chk("hold_instr", Instr, data);
            chk("hold_pc", PC, exp_pc);
            chk("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
        end
    endtask

    task automatic release_hold();
        instr_ready = 1'b1;
        step();
        instr_ready = 1'b0;
        exp_pc = exp_pc + 32'd4;
        chk("rel_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("rel_addr", imem_addr, exp_pc);
    endtask

    task automatic do_redirect(input logic [31:0] base, input logic [31:0] imm, input logic with_ready);
        redirect = 1'b1;
        redirect_base = base;
        ImmExt = imm;
        instr_ready = with_ready;
        step();
        redirect = 1'b0;
        instr_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        exp_pc = 32'd0;
    endtask

    initial begin
        // Reset state while held in reset.
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        chk("post_reset_addr", imem_addr, 32'd0);

        // First fetch, minimum latency, decode stalls 5 cycles.
        exp_pc = 32'd0;
        fetch_to_hold(0, 1, 5, 32'h0050_0093);
        release_hold();

        // Memory refuses for 3 cycles, accepts on the 4th.
        fetch_to_hold(3, 2, 0, mem_word(exp_pc));
        release_hold();

        // Redirect in HOLD: 0x10 + (-8) = 0x8.
        fetch_to_hold(0, 1, 0, mem_word(exp_pc));
        do_redirect(32'h10, 32'hFFFF_FFF8, 1'b0);
        exp_pc = 32'h8;
        chk("hold_redir_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("hold_redir_req", {31'd0, imem_req_valid}, 32'd1);
        chk("hold_redir_addr", imem_addr, exp_pc);

        // Same redirect coincident with instr_ready.
        fetch_to_hold(0, 1, 0, mem_word(exp_pc));
        do_redirect(32'h10, 32'hFFFF_FFF8, 1'b1);
        chk("hold_redir_rdy_addr", imem_addr, 32'h8);

        // Redirect in WAIT, stale response 2 cycles later.
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        do_redirect(32'h200, 32'h40, 1'b0);
        exp_pc = 32'h240;
        chk("wait_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step();
        imem_rsp_valid = 1'b0;
        chk("drop_no_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("drop_instr_kept", Instr, last_instr);
        chk("drop_req_addr", imem_addr, exp_pc);
        fetch_to_hold(0, 1, 0, mem_word(exp_pc));
        release_hold();

        // Redirect in REQ coincident with accept: drain, then refetch.
        wait_req();
        imem_req_ready = 1'b1;
        do_redirect(32'h300, 32'h0, 1'b0);
        imem_req_ready = 1'b0;
        exp_pc = 32'h300;
        chk("req_acc_redir_no_req", {31'd0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_BAD0;
        step();
        imem_rsp_valid = 1'b0;
        chk("req_acc_redir_instr", Instr, last_instr);

        // Redirect in WAIT with response in the same cycle.
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hCAFE_F00D;
        do_redirect(32'h3F0, 32'h10, 1'b0);
        imem_rsp_valid = 1'b0;
        exp_pc = 32'h400;
        chk("wait_rsp_redir_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("wait_rsp_redir_instr", Instr, last_instr);

        // Redirect in REQ without accept: address changes next cycle.
        wait_req();
        do_redirect(32'h480, 32'h80, 1'b0);
        exp_pc = 32'h500;
        wait_req();

        // Randomized fetch stream with occasional redirects from HOLD.
        for (int unsigned it = 0; it < 40; it++) begin
            fetch_to_hold($urandom_range(0, 2), $urandom_range(1, 3),
                          $urandom_range(0, 2), mem_word(exp_pc));
            if ($urandom_range(0, 2) == 0) begin
                logic [31:0] b, m;
                b = $urandom & 32'hFFFF_FFFC;
                m = $urandom & 32'hFFFF_FFFC;
                do_redirect(b, m, 1'($urandom_range(0, 1)));
                exp_pc = b + m;
                chk("rnd_redir_addr", imem_addr, exp_pc);
            end else begin
                release_hold();
            end
        end

        // Misaligned target 0x100 + 2.
        fetch_to_hold(0, 1, 0, mem_word(exp_pc));
        do_redirect(32'h100, 32'h2, 1'b0);
`ifdef FETCH_MISALIGN_CHK_EN
        chk("mis_err", {31'd0, misalign_err}, 32'd1);
        chk("mis_pc", PC, 32'h102);
        for (int unsigned i = 0; i < 4; i++) begin
            step();
            chk("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("halt_no_ivalid", {31'd0, instr_valid}, 32'd0);
        end
        chk("mis_err_sticky", {31'd0, misalign_err}, 32'd1);
`else
        chk("mis_forced_addr", imem_addr, 32'h100);
        chk("mis_err_zero", {31'd0, misalign_err}, 32'd0);
`endif
        pulse_reset();
        chk("after_reset_err", {31'd0, misalign_err}, 32'd0);

        // Reset asserted in WAIT: outputs return to reset values at once.
        fetch_to_hold(0, 1, 0, mem_word(exp_pc));
        release_hold();
        wait_req();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        step();
        reset_n = 1'b1;
        exp_pc = 32'd0;
        fetch_to_hold(0, 2, 0, mem_word(exp_pc));
        release_hold();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
